store_write_buffer: RTL and testbench
=====================================

// Module: store_write_buffer
// PURPOSE
//   Posted-write buffer between the MIPS core's store port (memwrite/dataadr/writedata) and data memory.
//   Accepts one store per cycle, queues up to DEPTH stores in order, and drains them to memory over a valid/ready handshake.
//   Stalls the core when full. Forwards the youngest buffered store to loads so read-after-write stays coherent.
//   Supports a flush request so the bench or the exception logic can wait until memory is up to date.
// PARAMETERS
//   DEPTH  4   number of buffered stores; power of two, >=2
//   AW     32  address width (byte address; word-aligned stores)
//   DW     32  data width
// PORTS
//   clk          in   1   single clock, all state updates on posedge
//   reset        in   1   asynchronous, active-high; clears all state
//   memwrite     in   1   core store request this cycle
//   dataadr      in   AW  core store byte address
//   writedata    in   DW  core store data
//   stall        out  1   buffer full; store is not accepted, core holds its request
//   rd_adr       in   AW  core load address for the forwarding lookup
//   rd_hit       out  1   a buffered store matches rd_adr[AW-1:2]
//   rd_data      out  DW  data of the youngest matching entry (0 when no hit)
//   mem_valid    out  1   head entry presented to memory
//   mem_ready    in   1   memory accepts the head entry this cycle
//   mem_adr      out  AW  head entry address
//   mem_wdata    out  DW  head entry data
//   flush        in   1   request to drain the buffer completely (level)
//   flush_done   out  1   one-cycle pulse: flush completed, buffer empty
//   empty        out  1   count == 0
//   count        out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//   Reset values: wr_ptr=rd_ptr=0, count=0, state=IDLE; stall=0, mem_valid=0, flush_done=0, rd_hit=0, empty=1.
//   Reset mid-operation discards every entry. No memory write completes after reset asserts.
//   push = memwrite & ~full & (state != FLUSHING). Entry {dataadr, writedata} is written at wr_ptr on the posedge.
//   stall = full | (memwrite & state==FLUSHING). Combinational from registered state plus memwrite only.
//   A push while full is never accepted, even when a pop happens in the same cycle.
//   pop = mem_valid & mem_ready. rd_ptr advances on the posedge.
//   mem_valid/mem_adr/mem_wdata come from the head entry. They stay stable while mem_valid=1 and mem_ready=0.
//   Latency: a store pushed at edge N is presented with mem_valid=1 from cycle N+1. It does not bypass to memory.
//   Simultaneous push+pop: count is unchanged and both pointers advance.
//   Pointers wrap modulo DEPTH. count ranges 0..DEPTH; full = (count==DEPTH).
//   Forwarding: combinational search over occupied entries, compared on address [AW-1:2].
//     The youngest match (nearest wr_ptr-1) wins. The head entry counts even while it is being popped.
//     A store being pushed in the same cycle is not visible to the lookup.
//   FSM:
//     IDLE      count==0, no flush. Push -> DRAIN. flush -> DONE (empty flush).
//     DRAIN     count>0. flush -> FLUSHING. Last entry popped with no push -> IDLE.
//     FLUSHING  pushes are blocked (stall while memwrite). Pops continue.
//               Last entry popped -> DONE.
//     DONE      flush_done=1 for exactly this cycle, then -> IDLE.
//               If flush is still high, the pulse repeats every other cycle.
//   flush that deasserts during FLUSHING does not abort the flush; the drain completes.
//   Addresses with [1:0]!=0 are stored verbatim. Alignment is the core's responsibility.
// STRUCTURE
//   Shared package mips_pkg: DW/AW defaults and the FSM state encoding (IDLE, DRAIN, FLUSHING, DONE, 2 bits).
//   One sub-module: swb_fifo_mem. It is a DEPTH x (AW+DW) register array with a write port and two async read ports (head and index).
//   The forwarding comparator and FSM live in the top.
// TESTING
//   1. Reset, then store adr=84 data=7 with mem_ready=1.
//      -> mem_valid=1 next cycle with mem_adr=84, mem_wdata=7. Popped on that cycle; empty=1 the cycle after.
//   2. mem_ready=0, push 5 stores (adr 0,4,8,12,16).
//      -> stall=1 after the 4th. The 5th is held until one pop.
//      -> Memory sees 0,4,8,12 in order, then 16.
//   3. Buffer stores adr=80 data=1, then adr=80 data=9 (mem_ready=0), with rd_adr=80.
//      -> rd_hit=1, rd_data=9. rd_adr=82 also hits (same word). rd_adr=84 -> rd_hit=0.
//   4. 3 entries buffered, flush=1, memwrite=1, mem_ready toggling.
//      -> stall=1 throughout. All 3 entries drain. flush_done pulses once, then the held store is accepted.
//   5. Push and pop every cycle for 10 cycles.
//      -> count constant at 1. Pointers wrap past DEPTH with no loss or duplication.
//   6. Assert reset with 2 entries while mem_valid=1.
//      -> mem_valid=0, count=0 and empty=1 immediately (async). No further mem writes.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-side definitions: default bus widths and the store-buffer FSM encoding.
package mips_pkg;

    localparam int MIPS_AW = 32;
    localparam int MIPS_DW = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        FLUSHING = 2'd2,
        DONE     = 2'd3
    } swb_state_t;

endpackage

// File: rtl/swb_fifo_mem.sv
// Entry storage for the store write buffer: one write port, an async head read,
// an async indexed data read, and the word-address tags for the forwarding search.
module swb_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [PW-1:0]                wr_idx,
    input  logic [AW-1:0]                wr_adr,
    input  logic [DW-1:0]                wr_data,
    input  logic [PW-1:0]                head_idx,
    output logic [AW-1:0]                head_adr,
    output logic [DW-1:0]                head_data,
    input  logic [PW-1:0]                rd_idx,
    output logic [DW-1:0]                idx_data,
    output logic [DEPTH-1:0][AW-3:0]     tags
);

    logic [DEPTH-1:0][AW-1:0] adr_mem;
    logic [DEPTH-1:0][DW-1:0] data_mem;

    // Contents need no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (we) begin
            adr_mem[wr_idx]  <= wr_adr;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign head_adr  = adr_mem[head_idx];
    assign head_data = data_mem[head_idx];
    assign idx_data  = data_mem[rd_idx];

    always_comb begin
        tags = '0;
        for (int i = 0; i < DEPTH; i++) tags[i] = adr_mem[i][AW-1:2];
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer between the core store port and data memory, with
// youngest-match load forwarding and a flush handshake.
module store_write_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = MIPS_AW,
    parameter int DW    = MIPS_DW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      memwrite,
    input  logic [AW-1:0]             dataadr,
    input  logic [DW-1:0]             writedata,
    output logic                      stall,
    input  logic [AW-1:0]             rd_adr,
    output logic                      rd_hit,
    output logic [DW-1:0]             rd_data,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [AW-1:0]             mem_adr,
    output logic [DW-1:0]             mem_wdata,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    swb_state_t state, state_nxt;
    logic [PW-1:0] wr_ptr, rd_ptr, hit_idx;
    logic [DEPTH-1:0][AW-3:0] tags;
    logic [DW-1:0] idx_data;
    logic full, push, pop, last_pop;
    logic unused_bits;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign mem_valid = ~empty;
    assign push      = memwrite & ~full & (state != FLUSHING);
    assign pop       = mem_valid & mem_ready;
    assign last_pop  = pop & (count == CW'(1));
    assign stall     = full | (memwrite & (state == FLUSHING));
    assign unused_bits = ^rd_adr[1:0];

    swb_fifo_mem #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_mem (
        .clk       (clk),
        .we        (push),
        .wr_idx    (wr_ptr),
        .wr_adr    (dataadr),
        .wr_data   (writedata),
        .head_idx  (rd_ptr),
        .head_adr  (mem_adr),
        .head_data (mem_wdata),
        .rd_idx    (hit_idx),
        .idx_data  (idx_data),
        .tags      (tags)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so the entry nearest wr_ptr-1 is the last to win.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        rd_hit  = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx = wr_ptr - PW'(i + 1);
            if ((i < int'(count)) && (tags[idx] == rd_adr[AW-1:2])) begin
                rd_hit  = 1'b1;
                hit_idx = idx;
            end
        end
        rd_data = rd_hit ? idx_data : '0;
    end

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            IDLE, DONE: begin
                flush_done = (state == DONE);
                if (push)       state_nxt = flush ? FLUSHING : DRAIN;
                else if (flush && state == IDLE) state_nxt = DONE;
                else            state_nxt = IDLE;
            end
            DRAIN: begin
                if (flush)                 state_nxt = FLUSHING;
                else if (last_pop && !push) state_nxt = IDLE;
            end
            FLUSHING: begin
                if (empty || last_pop) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (DEPTH=4).
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;
    logic [AW-1:0] rd_adr;
    logic          rd_hit;
    logic [DW-1:0] rd_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          flush;
    logic          flush_done;
    logic          empty;
    logic [$clog2(DEPTH):0] count;

    int tests = 0;
    int fails = 0;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .stall(stall), .rd_adr(rd_adr), .rd_hit(rd_hit),
        .rd_data(rd_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .flush(flush),
        .flush_done(flush_done), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        rd_adr = '0; mem_ready = 1'b0; flush = 1'b0;
        #12;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done got %b want 0", flush_done); end
        tests++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL reset_rd_hit got %b want 0", rd_hit); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (count !== 0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        mem_ready = 1'b1; memwrite = 1'b0; flush = 1'b0;
        for (int c = 0; c < 12 && !ok; c++) begin
            tick();
            if (empty) ok = 1;
        end
        tests++; if (!ok) begin fails++; $display("FAIL %s_drain got count %0d want 0", name, count); end
        mem_ready = 1'b0;
    endtask

    task automatic test_single_store();
        memwrite = 1'b1; dataadr = 84; writedata = 7; mem_ready = 1'b1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL single_stall got %b want 0", stall); end
        tick();
        memwrite = 1'b0;
        #1;
        tests++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", mem_valid); end
        tests++; if (mem_adr !== 84) begin fails++; $display("FAIL single_adr got %0d want 84", mem_adr); end
        tests++; if (mem_wdata !== 7) begin fails++; $display("FAIL single_wdata got %0d want 7", mem_wdata); end
        tests++; if (count !== 1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
        tick();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL single_empty got %b want 1", empty); end
        tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL single_valid_after got %b want 0", mem_valid); end
        mem_ready = 1'b0;
    endtask

    task automatic test_full_stall();
        int pops = 0;
        bit accepted = 0;
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            memwrite = 1'b1; dataadr = 4 * k; writedata = 100 + k;
            #1;
            tests++; if (stall !== 1'b0) begin fails++; $display("FAIL full_stall_%0d got %b want 0", k, stall); end
            tick();
        end
        dataadr = 16; writedata = 104;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall_5th got %b want 1", stall); end
        tests++; if (count !== 4) begin fails++; $display("FAIL full_count got %0d want 4", count); end
        tick();
        tests++; if (count !== 4) begin fails++; $display("FAIL full_held_count got %0d want 4", count); end
        mem_ready = 1'b1;
        for (int c = 0; c < 20 && pops < 5; c++) begin
            #1;
            if (c == 0) begin
                tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_push_pop_stall got %b want 1", stall); end
            end
            if (memwrite && !stall) accepted = 1;
            if (mem_valid) begin
                tests++; if (mem_adr !== 32'(4 * pops) || mem_wdata !== 32'(100 + pops)) begin
                    fails++; $display("FAIL full_order_%0d got adr %0d data %0d want adr %0d data %0d", pops, mem_adr, mem_wdata, 4 * pops, 100 + pops);
                end
                pops++;
            end
            tick();
            if (accepted) memwrite = 1'b0;
        end
        tests++; if (pops != 5 || !accepted) begin fails++; $display("FAIL full_pops got %0d accepted %0d want 5 accepted 1", pops, accepted); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_final_empty got %b want 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_forwarding();
        mem_ready = 1'b0;
        memwrite = 1'b1; dataadr = 80; writedata = 1; tick();
        dataadr = 80; writedata = 9; tick();
        memwrite = 1'b0; rd_adr = 80;
        #1;
        tests++; if (rd_hit !== 1'b1 || rd_data !== 9) begin fails++; $display("FAIL fwd_80 got hit %b data %0d want hit 1 data 9", rd_hit, rd_data); end
        rd_adr = 82;
        #1;
        tests++; if (rd_hit !== 1'b1 || rd_data !== 9) begin fails++; $display("FAIL fwd_82 got hit %b data %0d want hit 1 data 9", rd_hit, rd_data); end
        rd_adr = 84;
        #1;
        tests++; if (rd_hit !== 1'b0 || rd_data !== 0) begin fails++; $display("FAIL fwd_84 got hit %b data %0d want hit 0 data 0", rd_hit, rd_data); end
        memwrite = 1'b1; dataadr = 84; writedata = 5;
        #1;
        tests++; if (rd_hit !== 1'b0) begin fails++; $display("FAIL fwd_same_cycle got hit %b want 0", rd_hit); end
        tick();
        memwrite = 1'b0;
        #1;
        tests++; if (rd_hit !== 1'b1 || rd_data !== 5) begin fails++; $display("FAIL fwd_84_after got hit %b data %0d want hit 1 data 5", rd_hit, rd_data); end
        rd_adr = 80;
        #1;
        tests++; if (rd_data !== 9) begin fails++; $display("FAIL fwd_80_older got %0d want 9", rd_data); end
        drain("fwd");
    endtask

    task automatic test_flush();
        int pops = 0;
        int dones = 0;
        bit fin = 0;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            memwrite = 1'b1; dataadr = 200 + 4 * k; writedata = k; tick();
        end
        memwrite = 1'b0; flush = 1'b1;
        tick();
        memwrite = 1'b1; dataadr = 300; writedata = 3;
        for (int c = 0; c < 40 && !fin; c++) begin
            mem_ready = c[0];
            #1;
            if (mem_valid && mem_ready) begin
                tests++; if (mem_adr !== 32'(200 + 4 * pops)) begin fails++; $display("FAIL flush_order_%0d got %0d want %0d", pops, mem_adr, 200 + 4 * pops); end
                pops++;
            end
            if (flush_done) begin
                dones++;
                tests++; if (stall !== 1'b0 || count !== 0) begin fails++; $display("FAIL flush_done_state got stall %b count %0d want stall 0 count 0", stall, count); end
                flush = 1'b0;
                fin = 1;
            end else begin
                tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush_stall_c%0d got %b want 1", c, stall); end
            end
            tick();
        end
        memwrite = 1'b0; mem_ready = 1'b0;
        #1;
        tests++; if (!fin || pops != 3 || dones != 1) begin fails++; $display("FAIL flush_summary got fin %0d pops %0d dones %0d want 1 3 1", fin, pops, dones); end
        tests++; if (count !== 1 || mem_adr !== 300 || flush_done !== 1'b0) begin
            fails++; $display("FAIL flush_held_store got count %0d adr %0d done %b want 1 300 0", count, mem_adr, flush_done);
        end
        drain("flush");
    endtask

    task automatic test_flush_repeat();
        flush = 1'b1;
        #1;
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL frep_0 got %b want 0", flush_done); end
        tick();
        tests++; if (flush_done !== 1'b1) begin fails++; $display("FAIL frep_1 got %b want 1", flush_done); end
        tick();
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL frep_2 got %b want 0", flush_done); end
        tick();
        tests++; if (flush_done !== 1'b1) begin fails++; $display("FAIL frep_3 got %b want 1", flush_done); end
        flush = 1'b0;
        tick();
        tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL frep_4 got %b want 0", flush_done); end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        memwrite = 1'b1; dataadr = 0; writedata = 50;
        tick();
        for (int k = 0; k < 10; k++) begin
            dataadr = 4 * (k + 1); writedata = 50 + k + 1;
            #1;
            tests++; if (count !== 1 || mem_valid !== 1'b1 || mem_adr !== 32'(4 * k) || mem_wdata !== 32'(50 + k)) begin
                fails++; $display("FAIL b2b_%0d got count %0d adr %0d data %0d want 1 %0d %0d", k, count, mem_adr, mem_wdata, 4 * k, 50 + k);
            end
            tick();
        end
        memwrite = 1'b0;
        #1;
        tests++; if (count !== 1 || mem_adr !== 40) begin fails++; $display("FAIL b2b_last got count %0d adr %0d want 1 40", count, mem_adr); end
        tick();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got %b want 1", empty); end
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        memwrite = 1'b1; dataadr = 400; writedata = 1; tick();
        dataadr = 404; writedata = 2; tick();
        memwrite = 1'b0;
        #1;
        tests++; if (mem_valid !== 1'b1 || count !== 2) begin fails++; $display("FAIL rmid_pre got valid %b count %0d want 1 2", mem_valid, count); end
        #2 reset = 1'b1;
        #1;
        tests++; if (mem_valid !== 1'b0 || count !== 0 || empty !== 1'b1) begin
            fails++; $display("FAIL rmid_async got valid %b count %0d empty %b want 0 0 1", mem_valid, count, empty);
        end
        mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL rmid_hold_%0d got valid %b want 0", c, mem_valid); end
        end
        reset = 1'b0;
        tick();
        tests++; if (mem_valid !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL rmid_release got valid %b empty %b want 0 1", mem_valid, empty); end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_full_stall();
        test_forwarding();
        test_flush();
        test_flush_repeat();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
